// File: rtl/weight_medium.sv
// Weight-medium responder: stores weight words as BEATS lanes in block RAM and
// services single read/write requests as multi-beat sequences.
module weight_medium #(
    parameter int WEIGHT_LENGTH = 256,
    parameter int W_SIZE        = 1024,
    parameter int BRAM_WIDTH    = 256,
    parameter int BRAM_LATENCY  = 2,
    localparam int A_SIZE       = $clog2(WEIGHT_LENGTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [A_SIZE-1:0] addr_in,
    input  logic              read_enable_in,
    input  logic              write_enable_in,
    input  logic [W_SIZE-1:0] data_in,
    output logic [W_SIZE-1:0] data_out,
    output logic              finished_out,
    output logic              busy_out
);
    localparam int BEATS  = W_SIZE / BRAM_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DEPTH  = WEIGHT_LENGTH * BEATS;
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [A_SIZE:0]   WORD_LIMIT = (A_SIZE + 1)'(WEIGHT_LENGTH);

    typedef enum logic [1:0] {IDLE, READ_ISSUE, READ_DRAIN, WRITE} state_t;

    state_t              state_reg;
    logic [A_SIZE-1:0]   addr_reg;
    logic                oor_reg;
    logic [W_SIZE-1:0]   wdata_reg;
    logic [BEAT_W-1:0]   beat_reg;
    logic                busy_reg;
    logic                finished_reg;
    logic [W_SIZE-1:0]   data_out_reg;
    logic [W_SIZE-1:0]   asm_reg;
    logic [W_SIZE-1:0]   asm_next;

    logic [BRAM_WIDTH-1:0] mem [DEPTH];
    logic [BRAM_WIDTH-1:0] pipe_data [BRAM_LATENCY];
    logic                  pipe_valid_reg [BRAM_LATENCY];
    logic [BEAT_W-1:0]     pipe_beat_reg [BRAM_LATENCY];

    logic [BRAM_WIDTH-1:0] lane_of_word [BEATS];
    logic [BRAM_WIDTH-1:0] wr_lane;
    logic [A_SIZE-1:0]     ram_word;
    logic [RAM_AW-1:0]     ram_idx;
    logic                  wr_en;
    logic                  rd_en;
    logic                  last_lane_valid;

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
            assign lane_of_word[gi] = wdata_reg[gi*BRAM_WIDTH +: BRAM_WIDTH];
        end
    endgenerate

    // Out-of-range words are steered to word 0 so the RAM index stays legal;
    // their writes are suppressed and their read lanes forced to zero.
    assign ram_word = oor_reg ? '0 : addr_reg;
    assign ram_idx  = RAM_AW'(ram_word) * RAM_AW'(BEATS) + RAM_AW'(beat_reg);
    assign wr_lane  = lane_of_word[beat_reg];
    assign wr_en    = (state_reg == WRITE) && !oor_reg;
    assign rd_en    = (state_reg == READ_ISSUE);

    assign last_lane_valid = pipe_valid_reg[BRAM_LATENCY-1] &&
                             (pipe_beat_reg[BRAM_LATENCY-1] == LAST_BEAT);

    // RAM and its data pipeline carry no reset: contents survive reset, and
    // stale pipeline data is neutralised by the reset valid bits.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[ram_idx] <= wr_lane;
        end
        if (rd_en) begin
            pipe_data[0] <= mem[ram_idx];
        end
        for (int i = 1; i < BRAM_LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    always_comb begin
        asm_next = asm_reg;
        asm_next[pipe_beat_reg[BRAM_LATENCY-1]*BRAM_WIDTH +: BRAM_WIDTH] =
            oor_reg ? '0 : pipe_data[BRAM_LATENCY-1];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            oor_reg      <= 1'b0;
            wdata_reg    <= '0;
            beat_reg     <= '0;
            busy_reg     <= 1'b0;
            finished_reg <= 1'b0;
            data_out_reg <= '0;
            asm_reg      <= '0;
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                pipe_valid_reg[i] <= 1'b0;
                pipe_beat_reg[i]  <= '0;
            end
        end else begin
            finished_reg      <= 1'b0;
            pipe_valid_reg[0] <= rd_en;
            pipe_beat_reg[0]  <= beat_reg;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_beat_reg[i]  <= pipe_beat_reg[i-1];
            end
            if (pipe_valid_reg[BRAM_LATENCY-1]) begin
                asm_reg <= asm_next;
            end
            case (state_reg)
                IDLE: begin
                    if (write_enable_in || read_enable_in) begin
                        addr_reg  <= addr_in;
                        oor_reg   <= ({1'b0, addr_in} >= WORD_LIMIT);
                        wdata_reg <= data_in;
                        beat_reg  <= '0;
                        busy_reg  <= 1'b1;
                        // A write wins when both strobes arrive together.
                        state_reg <= write_enable_in ? WRITE : READ_ISSUE;
                    end
                end
                READ_ISSUE: begin
                    if (beat_reg == LAST_BEAT) begin
                        state_reg <= READ_DRAIN;
                    end else begin
                        beat_reg <= beat_reg + 1'b1;
                    end
                end
                READ_DRAIN: begin
                    if (last_lane_valid) begin
                        data_out_reg <= asm_next;
                        finished_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                WRITE: begin
                    if (beat_reg == LAST_BEAT) begin
                        finished_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end else begin
                        beat_reg <= beat_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign data_out     = data_out_reg;
    assign finished_out = finished_reg;
    assign busy_out     = busy_reg;

endmodule

// File: doc/weight_medium.md
# weight_medium

Responder side of the weight-medium handshake driven by the control unit: holds the ternary weight words that the control unit reads into its W register and writes back after stochastic-gradient updates. Each W_SIZE-bit word is stored as BEATS narrower lanes in an internal block RAM. Each request is serviced as a multi-beat sequence, with a fixed BRAM read latency. Completion is reported with a one-cycle finished pulse, and the read data is valid in that same cycle.

## Interface
- WEIGHT_LENGTH, 256, number of weight words; A_SIZE = $clog2(WEIGHT_LENGTH)
- W_SIZE, 1024, weight word width
- BRAM_WIDTH, 256, BRAM lane width; W_SIZE must be a multiple of it; BEATS = W_SIZE/BRAM_WIDTH
- BRAM_LATENCY, 2, BRAM read latency in cycles (address registered to data valid), ≥1
- clk_in  input  1  sole clock, rising edge
- rst_in  input  1  reset, synchronous, active-high
- addr_in  input  A_SIZE  word address, sampled only when a request is accepted
- read_enable_in  input  1  read request strobe
- write_enable_in  input  1  write request strobe
- data_in  input  W_SIZE  write data, sampled only when a write is accepted
- data_out  output  W_SIZE  read data
- finished_out  output  1  one-cycle completion pulse
- busy_out  output  1  high while a request is in service

## Operation
- Internal RAM: depth WEIGHT_LENGTH*BEATS, width BRAM_WIDTH, address {word, beat}. Lane k of a word holds bits [k*BRAM_WIDTH +: BRAM_WIDTH]. Contents initialise to zero and are never cleared by reset.
- States: IDLE, READ_ISSUE, READ_DRAIN, WRITE.
- IDLE accepts a request on any edge where a strobe is high. Acceptance captures addr_in and data_in, and raises busy_out.
- Read path:
  - READ_ISSUE issues beats 0..BEATS-1 on consecutive cycles.
  - READ_DRAIN waits for the BRAM_LATENCY pipeline to empty.
  - Each returning lane is written into its slice of an assembly register.
  - On the last lane: data_out is loaded with the full word, finished_out pulses, and the block returns to IDLE.
- Write path: WRITE writes beats 0..BEATS-1 on consecutive cycles. finished_out pulses with the last beat, then the block returns to IDLE.
- Both strobes high on the same edge: the write is serviced and the read is dropped.
- Strobes while busy_out is high are ignored; no queuing.
- Out-of-range address (addr_in ≥ WEIGHT_LENGTH, only possible when WEIGHT_LENGTH is not a power of two): writes are suppressed and reads return all zeros. The full timing and the finished pulse still occur.
- data_out holds its value from the finished pulse until the next read completes. Writes never disturb it.
- Read-after-write to the same address returns the new word; there is no stale-data window.

## Timing
- Reset values: data_out = 0, finished_out = 0, busy_out = 0, state = IDLE.
- Request accepted at edge t0:
  - busy_out is high from t0 until the edge that asserts finished_out.
  - Read: finished_out is high for the single cycle starting at edge t0 + BEATS + BRAM_LATENCY (defaults: t0+6). data_out is valid from that same edge.
  - Write: finished_out is high for the single cycle starting at edge t0 + BEATS (defaults: t0+4).
- finished_out and busy_out are never high together. The cycle in which finished_out is high is an IDLE cycle, so a strobe sampled at the next edge is accepted. This gives back-to-back service with no dead cycle.
- A strobe held high for more than one cycle is accepted only once if it is still high while busy. It is accepted again if it is still high when the block returns to IDLE. The requester drops the strobe after one cycle.
- Reset mid-operation:
  - The block returns to IDLE at the reset edge and no finished pulse is issued.
  - No further beats are written; beats already written remain in RAM.
  - BRAM pipeline data in flight is discarded.

## Test plan
- Round trip: write word 0x0123…(lane k = 256'hk repeated) to address 5, then read address 5 → finished at t0+4 for the write; read data_out equals the written word at t0+6; busy_out high t0..t0+5.
- Unwritten read: read address 200 after reset → data_out = 0, single finished pulse at t0+6.
- Back-to-back: write addr 0 = all-ones, write addr 255 = alternating 0xA…, each strobe issued the cycle after finished → reads of addr 0 and addr 255 return exactly those words; addr 1 reads 0.
- Simultaneous strobes: read and write both high to addr 7 with data X → RAM addr 7 = X; finished at t0+4; data_out unchanged.
- Reset at t0+2 of a write of all-ones to addr 3 → finished never pulses; busy_out = 0 after reset. Read addr 3 → lanes 0–1 all-ones, lanes 2–3 zero (default BEATS = 4).
- WEIGHT_LENGTH = 200: write 0xFF… to addr 210 → finished at t0+4, no RAM change. Read addr 210 → 0. Read addr 199 → 0.
